serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 139 +++++++++++++
 tb/tb_serial_addsub.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// A start in IDLE or DONE latches the operands; WIDTH cycles later the
// result and flags are loaded together and done pulses for one cycle.
module serial_addsub #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             load_c;
    logic             step_c;
    logic             last_c;
    logic             sum_bit_c;
    logic             carry_next_c;
    logic [WIDTH-1:0] sum_final_c;

    // Full-adder slice on the current LSBs; sum_final_c is the complete sum on the last step
    assign last_c       = (cnt == CW'(WIDTH - 1));
    assign sum_bit_c    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign sum_final_c  = {sum_bit_c, sum_sh};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; start is ignored while running
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shifters, carry, partial sum and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load_c) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            sum_sh <= '0;
            carry  <= sub;
            cnt    <= '0;
        end else if (step_c) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_final_c[WIDTH-1:1];
            carry  <= carry_next_c;
            cnt    <= cnt + CW'(1);
        end
    end

    // Registered status, and result/flags captured only on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zf     <= 1'b0;
            sf     <= 1'b0;
            of     <= 1'b0;
            cout   <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (step_c && last_c) begin
                result <= sum_final_c;
                zf     <= (sum_final_c == '0);
                sf     <= sum_bit_c;
                of     <= (a_sh[0] == b_sh[0]) && (sum_bit_c != a_sh[0]);
                cout   <= carry_next_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: expected results queued at start, checked on done.
module tb_serial_addsub;

    localparam int unsigned W = 64;

    typedef struct {
        logic [W-1:0] res;
        logic         zf;
        logic         sf;
        logic         of;
        logic         cout;
        int unsigned  done_cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zf;
    logic         sf;
    logic         of;
    logic         cout;

    int unsigned  n_vec;
    int unsigned  n_err;
    int unsigned  cyc;
    int unsigned  busy_cnt;
    logic [W-1:0] last_res;
    exp_t         q[$];
    exp_t         e;

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zf     (zf),
        .sf     (sf),
        .of     (of),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain WIDTH+1-bit arithmetic on the effective operand
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int unsigned dc);
        exp_t         r;
        logic [W-1:0] be;
        logic [W:0]   t;
        be         = s ? ~y : y;
        t          = {1'b0, x} + {1'b0, be} + (W+1)'(s);
        r.res      = t[W-1:0];
        r.cout     = t[W];
        r.zf       = (r.res == '0);
        r.sf       = r.res[W-1];
        r.of       = (x[W-1] == be[W-1]) && (r.res[W-1] != x[W-1]);
        r.done_cyc = dc;
        return r;
    endfunction

    // Must be called right after a negedge; start is sampled on the next posedge
    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        q.push_back(model(x, y, s, cyc + 1 + W));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        drive_start(x, y, s);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((q.size() != 0 || busy || done) && k < 4 * W) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4 * W) chk("timeout_idle", W'(1), W'(0));
    endtask

    // Output monitor, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (busy) begin
                busy_cnt++;
                chk("result_hold", result, last_res);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", W'(1), W'(0));
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("zf", W'(zf), W'(e.zf));
                    chk("sf", W'(sf), W'(e.sf));
                    chk("of", W'(of), W'(e.of));
                    chk("cout", W'(cout), W'(e.cout));
                    chk("latency", W'(cyc), W'(e.done_cyc));
                    chk("busy_cycles", W'(busy_cnt), W'(W));
                    last_res = e.res;
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int k;
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        busy_cnt = 0;
        last_res = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_flags", W'({zf, sf, of, cout}), W'(0));
        rst_n = 1'b1;

        // Directed cases
        run_op(W'(5), W'(3), 1'b0);
        wait_idle();
        chk("add_5_3_flags", W'({zf, sf, of, cout}), W'(4'b0000));
        run_op(W'(7), W'(7), 1'b1);
        wait_idle();
        run_op(64'h7FFF_FFFF_FFFF_FFFF, W'(1), 1'b0);
        wait_idle();

        // Subtract with borrow, then back-to-back start in the DONE cycle
        run_op(W'(0), W'(1), 1'b1);
        k = 0;
        while (!done && k < 2 * W) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2 * W) chk("timeout_done", W'(1), W'(0));
        drive_start(W'(2), W'(2), 1'b0);
        wait_idle();
        chk("b2b_result", result, W'(4));

        // Start pulsed mid-run is ignored
        run_op(W'(1), W'(1), 1'b0);
        repeat (9) @(negedge clk);
        a     = W'(9);
        b     = W'(9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("ignore_start_result", result, W'(2));

        // Asynchronous reset mid-run aborts without a done pulse
        run_op(W'(123), W'(456), 1'b0);
        repeat (29) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_result", result, W'(0));
        chk("abort_flags", W'({zf, sf, of, cout}), W'(0));
        q.delete();
        busy_cnt = 0;
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(W'(10), W'(4), 1'b1);
        wait_idle();
        chk("after_abort_cout", W'(cout), W'(1));

        // Random operands, including the sign boundary
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i == 0) y = x;
            if (i == 1) x = 64'h8000_0000_0000_0000;
            run_op(x, y, 1'($urandom_range(1, 0)));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
